// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: valid/ready stage that clears control to a bubble when empty, with registers updated on the falling clock edge.
// Define PIPE_STAGE_SKID_EN for a two-entry main+skid buffer with a registered in_ready; without it the stage holds one entry.
module pipe_stage_buf #(
  parameter int CTRL_W = 25,
  parameter int DATA_W = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              do_push, do_pop;

  assign do_push = in_valid & in_ready;
  assign do_pop  = main_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low while the skid is occupied, so only a release can happen
      if (do_pop) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (do_push && (!main_valid_q || do_pop)) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end else if (do_push) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end else if (do_pop) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  // Single entry: accept while empty or while the head leaves on the same edge
  assign in_ready = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (do_push) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end else if (do_pop) begin
      main_valid_d = 1'b0;
    end
  end

  assign occupancy = {1'b0, main_valid_q};
`endif

  always_ff @(negedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
    end
  end

  // Data keeps its last value after release; only control is bubbled
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

endmodule
